pll_lock_sequencer: RTL

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL power-up and lock supervisor: sequences PLL enable/reset/settle, watches the
// synchronized trim word for stability, and switches clk_sel to the PLL once locked.
module pll_lock_sequencer #(
    parameter int RST_CYCLES  = 4,
    parameter int LOSS_CYCLES = 3
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        start,
    input  logic        bypass,
    input  logic [4:0]  div_cfg,
    input  logic [25:0] trim,
    input  logic [11:0] settle_cycles,
    input  logic [7:0]  stable_cycles,
    input  logic [15:0] timeout_cycles,
    output logic        pll_enable,
    output logic        pll_resetb,
    output logic [4:0]  pll_div,
    output logic        clk_sel,
    output logic        locked,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RESET   = 3'd1,
        SETTLE  = 3'd2,
        MONITOR = 3'd3,
        LOCKED  = 3'd4,
        FAULT   = 3'd5
    } st_t;

    localparam int RW = $clog2(RST_CYCLES + 2);
    localparam int LW = $clog2(LOSS_CYCLES + 2);

    st_t           st;
    logic [25:0]   t_s1, t_s2, t_prev;
    logic          changed;
    logic [RW-1:0] rst_cnt;
    logic [LW-1:0] loss_cnt;
    logic [11:0]   settle_cnt, settle_max;
    logic [7:0]    stable_cnt, stable_max, stable_inc;
    logic [15:0]   tmo_cnt, tmo_inc;

    // {pll_enable, pll_resetb, clk_sel, locked, fault} for the state being entered
    function automatic logic [4:0] outs(st_t s);
        case (s)
            RESET:   outs = 5'b10000;
            SETTLE:  outs = 5'b11000;
            MONITOR: outs = 5'b11000;
            LOCKED:  outs = 5'b11110;
            FAULT:   outs = 5'b00001;
            default: outs = 5'b00000;
        endcase
    endfunction

    always_comb begin
        changed    = (t_s2 != t_prev);
        settle_max = (settle_cycles == '0) ? 12'd1 : settle_cycles;
        stable_max = (stable_cycles == '0) ? 8'd1 : stable_cycles;
        stable_inc = (stable_cnt == '1) ? stable_cnt : stable_cnt + 8'd1;
        tmo_inc    = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + 16'd1;
    end

    assign state = st;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            st         <= IDLE;
            t_s1       <= '0;
            t_s2       <= '0;
            t_prev     <= '0;
            rst_cnt    <= '0;
            loss_cnt   <= '0;
            settle_cnt <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            pll_div    <= '0;
            {pll_enable, pll_resetb, clk_sel, locked, fault} <= '0;
        end else begin
            t_s1   <= trim;
            t_s2   <= t_s1;
            t_prev <= t_s2;
            if (st != IDLE && (!start || bypass)) begin
                st         <= IDLE;
                pll_div    <= '0;
                rst_cnt    <= '0;
                loss_cnt   <= '0;
                settle_cnt <= '0;
                stable_cnt <= '0;
                tmo_cnt    <= '0;
                {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(IDLE);
            end else begin
                case (st)
                    IDLE: if (start && !bypass) begin
                        st      <= RESET;
                        pll_div <= div_cfg;
                        rst_cnt <= '0;
                        {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(RESET);
                    end
                    RESET: if (int'(rst_cnt) + 1 >= RST_CYCLES) begin
                        st         <= SETTLE;
                        settle_cnt <= '0;
                        {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(SETTLE);
                    end else begin
                        rst_cnt <= rst_cnt + RW'(1);
                    end
                    SETTLE: if (settle_cnt + 12'd1 >= settle_max) begin
                        st         <= MONITOR;
                        stable_cnt <= '0;
                        tmo_cnt    <= '0;
                        {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(MONITOR);
                    end else begin
                        settle_cnt <= settle_cnt + 12'd1;
                    end
                    // Lock is judged on the registered stable count so it wins over a same-cycle timeout.
                    MONITOR: if (stable_cnt >= stable_max) begin
                        st       <= LOCKED;
                        loss_cnt <= '0;
                        {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(LOCKED);
                    end else if (timeout_cycles != '0 && tmo_inc >= timeout_cycles) begin
                        st <= FAULT;
                        {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(FAULT);
                    end else begin
                        stable_cnt <= changed ? 8'd0 : stable_inc;
                        tmo_cnt    <= tmo_inc;
                    end
                    LOCKED: if (changed) begin
                        if (int'(loss_cnt) + 1 >= LOSS_CYCLES) begin
                            st         <= MONITOR;
                            loss_cnt   <= '0;
                            stable_cnt <= '0;
                            tmo_cnt    <= '0;
                            {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(MONITOR);
                        end else begin
                            loss_cnt <= loss_cnt + LW'(1);
                        end
                    end else begin
                        loss_cnt <= '0;
                    end
                    FAULT: ;
                    default: begin
                        st <= IDLE;
                        {pll_enable, pll_resetb, clk_sel, locked, fault} <= outs(IDLE);
                    end
                endcase
            end
        end
    end

endmodule
